present_rr_sched: RTL and testbench

//   Shares one PRESENT-80/128 cipher core between N_REQ requesters (DMA engines, CPU path) using round-robin.
//   Per job: latches the winner's plaintext and key, sequences core start/eoc, returns the ciphertext.

---
 rtl/present_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/present_rr_sched.sv | 150 +++++++++++++++
 tb/tb_present_rr_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_sched_pkg.sv
// Shared types and widths for the PRESENT core round-robin scheduler.
package present_sched_pkg;

  localparam int unsigned PT_W  = 64;
  localparam int unsigned KEY_W = 128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Scan N positions starting at ptr; the sum is one bit wider so the wrap is at N, not 2**IW.
  always_comb begin
    logic          found;
    logic [IW:0]   pos;
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    pos        = '0;
    for (int k = 0; k < int'(N); k++) begin
      pos = {1'b0, ptr} + (IW + 1)'(k);
      if (pos >= (IW + 1)'(N)) begin
        pos = pos - (IW + 1)'(N);
      end
      if (!found && req[pos[IW-1:0]]) begin
        found                   = 1'b1;
        gnt_onehot[pos[IW-1:0]] = 1'b1;
        gnt_idx                 = pos[IW-1:0];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/present_rr_sched.sv
// Round-robin scheduler sharing one PRESENT cipher core among N_REQ requesters.
// Optional WAIT-state watchdog enabled by defining PRESENT_SCHED_TIMEOUT_EN.
module present_rr_sched
  import present_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*64-1:0]    req_pt,
  input  logic [N_REQ*128-1:0]   req_key,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       done,
  output logic [63:0]            rsp_ct,
  output logic                   err,
  output logic                   busy,
  output logic                   core_start,
  output logic [63:0]            core_pt,
  output logic [127:0]           core_key,
  input  logic                   core_eoc,
  input  logic [63:0]            core_ct
);

  localparam int unsigned IW = $clog2(N_REQ);

  sched_state_t state_q, state_d;

  logic [IW-1:0]    ptr_q, win_q, gnt_idx, ptr_next;
  logic [N_REQ-1:0] gnt_onehot, ack_q;
  logic             any_req, core_start_q, eoc_ok, to_hit;
  logic [PT_W-1:0]  core_pt_q, rsp_ct_q;
  logic [KEY_W-1:0] core_key_q;

  logic [N_REQ-1:0][PT_W-1:0]  pt_arr;
  logic [N_REQ-1:0][KEY_W-1:0] key_arr;

  assign pt_arr  = req_pt;
  assign key_arr = req_key;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any_req)
  );

  // An eoc seen while start is still on the wire belongs to the previous job.
  assign eoc_ok   = core_eoc & ~core_start_q;
  assign ptr_next = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);

`ifdef PRESENT_SCHED_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        err_q;

  assign to_hit = (to_cnt_q == 16'(TIMEOUT_CYC - 1));

  // Watchdog: count WAIT cycles; remember whether the job ended by timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == S_START) begin
        to_cnt_q <= '0;
      end else if (state_q == S_WAIT) begin
        to_cnt_q <= to_cnt_q + 16'd1;
      end
      if (state_q == S_WAIT) begin
        err_q <= to_hit & ~eoc_ok;
      end
    end
  end

  assign err = (state_q == S_RESP) & err_q;
`else
  logic unused_timeout_cfg;

  assign to_hit             = 1'b0;
  assign unused_timeout_cfg = |32'(TIMEOUT_CYC);
  assign err                = 1'b0;
`endif

  // Job sequencing FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (eoc_ok || to_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant capture, operand/result registers and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q        <= '0;
      win_q        <= '0;
      ptr_q        <= '0;
      core_start_q <= 1'b0;
      core_pt_q    <= '0;
      core_key_q   <= '0;
      rsp_ct_q     <= '0;
    end else begin
      ack_q        <= '0;
      core_start_q <= (state_q == S_START);
      if (state_q == S_IDLE && any_req) begin
        ack_q      <= gnt_onehot;
        win_q      <= gnt_idx;
        core_pt_q  <= pt_arr[gnt_idx];
        core_key_q <= key_arr[gnt_idx];
      end
      if (state_q == S_WAIT) begin
        if (eoc_ok) begin
          rsp_ct_q <= core_ct;
        end else if (to_hit) begin
          rsp_ct_q <= '0;
        end
      end
      if (state_q == S_RESP) begin
        ptr_q <= ptr_next;
      end
    end
  end

  assign ack        = ack_q;
  assign done       = (state_q == S_RESP) ? (N_REQ'(1) << win_q) : '0;
  assign rsp_ct     = rsp_ct_q;
  assign busy       = (state_q != S_IDLE);
  assign core_start = core_start_q;
  assign core_pt    = core_pt_q;
  assign core_key   = core_key_q;

endmodule

// File: tb/tb_present_rr_sched.sv
// Bench for present_rr_sched with a behavioural PRESENT core (eoc lat cycles after start,
// ct = pt ^ key[63:0]). Expected grants/results are queued per job and popped on ack/done.
module tb_present_rr_sched;

  localparam int N = 4;
`ifdef PRESENT_SCHED_TIMEOUT_EN
  localparam int TO      = 8;
  localparam int LAT_DEF = 5;
`else
  localparam int TO      = 64;
  localparam int LAT_DEF = 33;
`endif

  typedef struct {
    int          idx;
    logic [63:0] ct;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*64-1:0]  req_pt = '0;
  logic [N*128-1:0] req_key = '0;
  logic [N-1:0]     ack, done;
  logic [63:0]      rsp_ct;
  logic             err, busy, core_start;
  logic [63:0]      core_pt;
  logic [127:0]     core_key;
  logic             core_eoc;
  logic [63:0]      core_ct;

  logic [63:0]  pt_v[N];
  logic [127:0] key_v[N];
  exp_t         exp_ack[$];
  exp_t         exp_done[$];

  int passed = 0;
  int total  = 0;
  int n_ack  = 0;
  int n_done = 0;
  int ack_cyc = 0;
  int done_cyc = 0;
  int cyc;
  int lat = LAT_DEF;
  bit no_eoc = 1'b0;
  int eoc_cnt;

  always #5 clk = ~clk;

  present_rr_sched #(
    .N_REQ       (N),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_pt     (req_pt),
    .req_key    (req_key),
    .ack        (ack),
    .done       (done),
    .rsp_ct     (rsp_ct),
    .err        (err),
    .busy       (busy),
    .core_start (core_start),
    .core_pt    (core_pt),
    .core_key   (core_key),
    .core_eoc   (core_eoc),
    .core_ct    (core_ct)
  );

  // Cycle count since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Behavioural core: eoc is sampled by the scheduler lat edges after it samples start.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eoc_cnt  <= 0;
      core_eoc <= 1'b0;
      core_ct  <= '0;
    end else begin
      core_eoc <= 1'b0;
      if (core_start) begin
        eoc_cnt <= lat - 1;
        core_ct <= core_pt ^ core_key[63:0];
      end else if (eoc_cnt > 0) begin
        eoc_cnt <= eoc_cnt - 1;
        if (eoc_cnt == 1 && !no_eoc) core_eoc <= 1'b1;
      end
    end
  end

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one = 1;
    return one << i;
  endfunction

  // Scoreboard monitor.
  initial begin
    bit   start_due = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        start_due = 1'b0;
      end else begin
        if (start_due) begin
          total++;
          if (core_start !== 1'b1) $display("FAIL start_after_ack: got %b want 1", core_start);
          else passed++;
        end
        start_due = (ack !== '0);
        if (ack !== '0) begin
          n_ack++;
          ack_cyc = cyc;
          total++;
          if (exp_ack.size() == 0) begin
            $display("FAIL unexpected_ack: got %b want none", ack);
          end else begin
            e = exp_ack.pop_front();
            if (ack !== oh(e.idx)) $display("FAIL ack_order: got %b want %b", ack, oh(e.idx));
            else passed++;
          end
        end
        if (done !== '0) begin
          n_done++;
          done_cyc = cyc;
          total++;
          if (exp_done.size() == 0) begin
            $display("FAIL unexpected_done: got %b want none", done);
          end else begin
            e = exp_done.pop_front();
            if (done !== oh(e.idx) || rsp_ct !== e.ct || err !== e.err)
              $display("FAIL done_result: got done=%b ct=%h err=%b want done=%b ct=%h err=%b",
                       done, rsp_ct, err, oh(e.idx), e.ct, e.err);
            else passed++;
          end
        end
      end
    end
  end

  task automatic set_ops(input int i, input logic [63:0] p, input logic [127:0] k);
    pt_v[i]  = p;
    key_v[i] = k;
    req_pt[64*i +: 64]   = p;
    req_key[128*i +: 128] = k;
  endtask

  task automatic push_job(input int i, input logic timeout);
    exp_t e;
    e.idx = i;
    e.err = timeout;
    e.ct  = timeout ? 64'h0 : (pt_v[i] ^ key_v[i][63:0]);
    exp_ack.push_back(e);
    exp_done.push_back(e);
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    req     = '0;
    repeat (2) @(negedge clk);
    exp_ack.delete();
    exp_done.delete();
    n_ack  = 0;
    n_done = 0;
  endtask

  task automatic release_reset(input logic [N-1:0] r);
    req     = r;
    reset_n = 1'b1;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int k = 0;
    while (n_ack < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (n_ack < target) $display("FAIL wait_ack: got %0d acks want %0d", n_ack, target);
    else passed++;
  endtask

  task automatic wait_dones(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (n_done < target) $display("FAIL wait_done: got %0d dones want %0d", n_done, target);
    else passed++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) set_ops(i, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    reset_n = 1'b0;
    req     = '1;
    repeat (3) @(negedge clk);
    total++;
    if ({ack, done, err, busy, core_start} !== '0)
      $display("FAIL reset_ctrl: got %b want 0", {ack, done, err, busy, core_start});
    else passed++;
    total++;
    if ({rsp_ct, core_pt, core_key} !== '0) $display("FAIL reset_data: got nonzero want 0");
    else passed++;
  endtask

  task automatic test_single();
    hold_reset();
    set_ops(0, 64'h0, 128'h0);
    push_job(0, 1'b0);
    release_reset(4'b0001);
    wait_acks(1, 10);
    req = '0;
    total++;
    if (ack_cyc !== 1) $display("FAIL single_ack_cycle: got %0d want 1", ack_cyc);
    else passed++;
    wait_dones(1, 80);
    total++;
    if (done_cyc - ack_cyc !== lat + 2)
      $display("FAIL single_latency: got %0d want %0d", done_cyc - ack_cyc, lat + 2);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_all_four();
    hold_reset();
    for (int i = 0; i < N; i++) set_ops(i, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < N; i++) push_job(i, 1'b0);
    push_job(0, 1'b0);
    release_reset('1);
    wait_acks(5, 400);
    req = '0;
    wait_dones(5, 100);
  endtask

  task automatic test_withdraw();
    int a0 = n_ack;
    int d0 = n_done;
    set_ops(0, 64'h0123_4567_89ab_cdef, 128'hdead_beef_0000_1111_2222_3333_4444_5555);
    push_job(0, 1'b0);
    req[0] = 1'b1;
    wait_acks(a0 + 1, 20);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    set_ops(2, 64'hffff_0000_ffff_0000, 128'h1);
    req[2] = 1'b1;
    repeat (10) @(negedge clk);
    req[2] = 1'b0;
    wait_dones(d0 + 1, 80);
    repeat (12) @(negedge clk);
    total++;
    if (n_ack !== a0 + 1) $display("FAIL withdraw_no_ack: got %0d acks want %0d", n_ack, a0 + 1);
    else passed++;
    total++;
    if (rsp_ct !== (pt_v[0] ^ key_v[0][63:0]))
      $display("FAIL rsp_hold: got %h want %h", rsp_ct, pt_v[0] ^ key_v[0][63:0]);
    else passed++;
  endtask

  task automatic test_wrap();
    int a0 = n_ack;
    int d0 = n_done;
    set_ops(2, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    push_job(2, 1'b0);
    req = 4'b0100;
    wait_acks(a0 + 1, 20);
    req = '0;
    wait_dones(d0 + 1, 80);
    set_ops(0, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    set_ops(3, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    push_job(3, 1'b0);
    push_job(0, 1'b0);
    req = 4'b1001;
    wait_acks(a0 + 3, 120);
    req = '0;
    wait_dones(d0 + 3, 80);
  endtask

  task automatic test_reset_mid();
    hold_reset();
    set_ops(1, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    push_job(1, 1'b0);
    release_reset(4'b0010);
    wait_acks(1, 10);
    req = '0;
    wait_dones(1, 80);
    set_ops(2, 64'h5a5a_5a5a_5a5a_5a5a, 128'h0f0f);
    push_job(2, 1'b0);
    req = 4'b0100;
    wait_acks(2, 20);
    req = '0;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy);
    else passed++;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({ack, done, err, busy, core_start} !== '0 || core_pt !== '0 || core_key !== '0)
      $display("FAIL mid_reset_outputs: got ctrl=%b pt=%h want 0", {ack, done, err, busy, core_start},
               core_pt);
    else passed++;
    hold_reset();
    set_ops(1, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    push_job(1, 1'b0);
    push_job(2, 1'b0);
    release_reset(4'b0110);
    wait_acks(1, 10);
    req[1] = 1'b0;
    total++;
    if (ack_cyc !== 1) $display("FAIL mid_rerun_ack_cycle: got %0d want 1", ack_cyc);
    else passed++;
    wait_acks(2, 100);
    req = '0;
    wait_dones(2, 80);
  endtask

`ifdef PRESENT_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    hold_reset();
    no_eoc = 1'b1;
    set_ops(3, 64'h1111_2222_3333_4444, 128'habcd);
    push_job(3, 1'b1);
    release_reset(4'b1000);
    wait_acks(1, 10);
    req = '0;
    wait_dones(1, 40);
    total++;
    if (done_cyc - ack_cyc !== TO + 1)
      $display("FAIL timeout_latency: got %0d want %0d", done_cyc - ack_cyc, TO + 1);
    else passed++;
    no_eoc = 1'b0;
    // eoc lands on the same edge as the watchdog: eoc must win.
    lat = TO - 1;
    set_ops(1, 64'h9999_8888_7777_6666, 128'h1234);
    push_job(1, 1'b0);
    req = 4'b0010;
    wait_acks(2, 20);
    req = '0;
    wait_dones(2, 40);
    lat = LAT_DEF;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_withdraw();
    test_wrap();
    test_reset_mid();
`ifdef PRESENT_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    repeat (4) @(negedge clk);
    total++;
    if (exp_done.size() != 0 || exp_ack.size() != 0)
      $display("FAIL leftover_expectations: got %0d/%0d want 0", exp_ack.size(), exp_done.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
